// File: rtl/sramgen_sram_pipe_v2.sv
// Single-port SRAM with lane write mask, self-clearing init sequence
// and a fully pipelined read path of configurable latency.
module sramgen_sram_pipe_v2 #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 9,
  parameter int WMASK_WIDTH  = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE  = DATA_WIDTH / WMASK_WIDTH;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("READ_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   count;
  logic [ADDR_WIDTH-1:0]   count_next;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [WMASK_WIDTH-1:0]  wr_mask;
  logic                    rd_accept;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [READ_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0]   dat [READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // INIT borrows the write port to zero one word per cycle.
  always_comb begin
    state_next = state;
    count_next = count;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = addr;
    wr_data    = din;
    wr_mask    = wmask;
    unique case (state)
      INIT: begin
        wr_en      = 1'b1;
        wr_addr    = count;
        wr_data    = '0;
        wr_mask    = '1;
        count_next = count + ADDR_WIDTH'(1);
        if (count == {ADDR_WIDTH{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        wr_en     = req_valid && we;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  assign rd_accept = req_valid && req_ready && !we;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < WMASK_WIDTH; k++) begin
        if (wr_mask[k]) begin
          mem[wr_addr][k*LANE +: LANE] <= wr_data[k*LANE +: LANE];
        end
      end
    end
  end

  // Data stages only advance with a valid token, so the last stage
  // holds the most recent response between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= rd_accept;
      if (rd_accept) begin
        dat[0] <= mem[addr];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign rsp_valid = vld[READ_LATENCY-1];
  assign dout      = dat[READ_LATENCY-1];

endmodule

// File: tb/tb_sramgen_sram_pipe_v2.sv
// Scoreboard bench: two instances (read latency 1 and 3) share stimulus;
// per-instance monitors pop expected data and due cycle on each rsp_valid.
module tb_sramgen_sram_pipe_v2;

  localparam int DW = 64;
  localparam int AW = 9;
  localparam int LA = 1;
  localparam int LB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          we = 1'b0;
  logic [7:0]    wmask = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;

  logic          ready_a, rv_a, done_a;
  logic          ready_b, rv_b, done_b;
  logic [DW-1:0] dout_a, dout_b;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  sramgen_sram_pipe_v2 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .WMASK_WIDTH(8), .READ_LATENCY(LA)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(ready_a),
    .we(we), .wmask(wmask), .addr(addr), .din(din),
    .rsp_valid(rv_a), .dout(dout_a), .init_done(done_a)
  );

  sramgen_sram_pipe_v2 #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .WMASK_WIDTH(8), .READ_LATENCY(LB)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(ready_b),
    .we(we), .wmask(wmask), .addr(addr), .din(din),
    .rsp_valid(rv_b), .dout(dout_b), .init_done(done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rv_a) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_rsp: got dout %h expected no rsp", dout_a);
        end else begin
          ea = qa.pop_front();
          chk("a_rsp_data", dout_a, ea.data);
          chk("a_rsp_cycle", 64'(cyc), 64'(ea.due));
        end
      end
      if (qa.size() > 0 && qa[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL a_rsp_missing: got none expected %h at %0d",
                 qa[0].data, qa[0].due);
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rv_b) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_rsp: got dout %h expected no rsp", dout_b);
        end else begin
          eb = qb.pop_front();
          chk("b_rsp_data", dout_b, eb.data);
          chk("b_rsp_cycle", 64'(cyc), 64'(eb.due));
        end
      end
      if (qb.size() > 0 && qb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL b_rsp_missing: got none expected %h at %0d",
                 qb[0].data, qb[0].due);
        void'(qb.pop_front());
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d,
                    input logic [7:0] m);
    req_valid = 1'b1;
    we        = 1'b1;
    addr      = a;
    din       = d;
    wmask     = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    we        = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [63:0] exp);
    req_valid = 1'b1;
    we        = 1'b0;
    addr      = a;
    qa.push_back('{exp, cyc + LA});
    qb.push_back('{exp, cyc + LB});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n;
    for (n = 1; n <= 1000; n++) begin
      @(posedge clk);
      #1;
      if (ready_a) break;
    end
    req_valid = 1'b0;
    we        = 1'b0;
    chk("init_cycles", 64'(n), 64'd512);
    chk("ready_b_at_init", {63'd0, ready_b}, 64'd1);
    chk("done_a_at_init", {63'd0, done_a}, 64'd1);
    chk("done_b_at_init", {63'd0, done_b}, 64'd1);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_a"}, {63'd0, ready_a}, 64'd0);
    chk({tag, "_ready_b"}, {63'd0, ready_b}, 64'd0);
    chk({tag, "_rv_a"}, {63'd0, rv_a}, 64'd0);
    chk({tag, "_rv_b"}, {63'd0, rv_b}, 64'd0);
    chk({tag, "_dout_a"}, dout_a, 64'd0);
    chk({tag, "_dout_b"}, dout_b, 64'd0);
    chk({tag, "_done_a"}, {63'd0, done_a}, 64'd0);
    chk({tag, "_done_b"}, {63'd0, done_b}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");

    // Release reset with a write to addr 7 pending through INIT.
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b1;
    we        = 1'b1;
    addr      = 9'd7;
    din       = '1;
    wmask     = 8'hFF;
    @(negedge clk);
    chk_reset_outputs("init");
    wait_init();

    rd(9'd0,   64'd0);
    rd(9'd511, 64'd0);
    rd(9'd7,   64'd0);

    wr(9'd5, 64'h1122334455667788, 8'hFF);
    rd(9'd5, 64'h1122334455667788);
    wr(9'd5, '1, 8'h81);
    rd(9'd5, 64'hFF223344556677FF);
    wr(9'd5, 64'd0, 8'h00);
    rd(9'd5, 64'hFF223344556677FF);
    drain();

    wr(9'd1, 64'h0101010101010101, 8'hFF);
    wr(9'd2, 64'hDEADBEEFCAFEF00D, 8'hFF);
    wr(9'd3, 64'h0123456789ABCDEF, 8'hFF);
    wr(9'd3, '1, 8'h10);
    rd(9'd1, 64'h0101010101010101);
    rd(9'd2, 64'hDEADBEEFCAFEF00D);
    rd(9'd3, 64'h012345FF89ABCDEF);
    drain();
    chk("dout_a_hold", dout_a, 64'h012345FF89ABCDEF);
    chk("dout_b_hold", dout_b, 64'h012345FF89ABCDEF);

    rd(9'd2, 64'hDEADBEEFCAFEF00D);
    wr(9'd2, 64'd0, 8'hFF);
    rd(9'd2, 64'd0);
    drain();

    rd(9'd5, 64'hFF223344556677FF);
    rd(9'd1, 64'h0101010101010101);
    #1;
    rst = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk_reset_outputs("arst");
    repeat (3) begin
      @(negedge clk);
      chk("arst_hold_rv_a", {63'd0, rv_a}, 64'd0);
      chk("arst_hold_rv_b", {63'd0, rv_b}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init();
    rd(9'd5, 64'd0);
    rd(9'd7, 64'd0);
    rd(9'd3, 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
